// File: rtl/inv_sub_round_if.sv
// Handshake bundle for inv_sub_round: state/key input channel and result output channel.
// The master drives inputs and out_ready; the slave (the round block) drives the rest.
interface inv_sub_round_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;

    modport master (
        output in_valid, in_state, in_key, out_ready,
        input  in_ready, out_valid, out_state
    );

    modport slave (
        input  in_valid, in_state, in_key, out_ready,
        output in_ready, out_valid, out_state
    );
endinterface

// File: rtl/inv_sub_round.sv
// Decryption half-round: InvShiftRows on capture, then LANES bytes per cycle of
// InvSubBytes + AddRoundKey in place; result waits in DONE for the next stage.
//
//   state | meaning
//   IDLE  | ready for a new state/key pair
//   BUSY  | substituting bytes idx..idx+LANES-1 each cycle
//   DONE  | out_state holds the finished result, waiting for out_ready
module inv_sub_round #(
    parameter int LANES = 1
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           clr,
    inv_sub_round_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state, state_nxt;
    logic [3:0]       idx;
    logic [15:0][7:0] work, key, work_nxt, shifted, in_b;
    logic             last_step, capture;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Inverse affine transform followed by the field inverse x^254 (0 maps to 0).
    function automatic logic [7:0] inv_sbox(input logic [7:0] v);
        logic [7:0] a, sq, r;
        a  = {v[6:0], v[7]} ^ {v[4:0], v[7:5]} ^ {v[1:0], v[7:2]} ^ 8'h05;
        sq = a;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gmul(sq, sq);
            r  = gmul(r, sq);
        end
        return r;
    endfunction

    // Byte j of the bus lives in packed element 15-j, so byte 0 stays in the MSBs.
    assign in_b = bus.in_state;

    always_comb begin
        shifted = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shifted[15 - (4 * c + r)] = in_b[15 - (4 * ((c - r + 4) % 4) + r)];
            end
        end
    end

    always_comb begin
        logic [3:0] lane;
        logic [3:0] pos;
        work_nxt = work;
        lane     = idx;
        pos      = 4'd15 - idx;
        for (int l = 0; l < LANES; l++) begin
            lane           = idx + 4'(l);
            pos            = 4'd15 - lane;
            work_nxt[pos]  = inv_sbox(work[pos]) ^ key[pos];
        end
    end

    assign last_step = (idx == 4'(16 - LANES));
    assign capture   = (state == IDLE) && bus.in_valid && !clr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_nxt = BUSY;
            BUSY:    if (last_step)     state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
        if (clr) state_nxt = IDLE;
    end

    // idx wraps to 0 on the final step, so it never leaves 0..15.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx  <= '0;
            work <= '0;
            key  <= '0;
        end else if (clr) begin
            idx <= '0;
        end else if (capture) begin
            work <= shifted;
            key  <= bus.in_key;
            idx  <= '0;
        end else if (state == BUSY) begin
            work <= work_nxt;
            idx  <= idx + 4'(LANES);
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.out_state = work;
endmodule

// File: tb/tb_inv_sub_round.sv
// Bench for inv_sub_round: one instance per legal LANES value, directed known-answer
// vectors, stall/abort sequences and random back-to-back blocks against a table model.
module tb_inv_sub_round;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [4:0]   in_valid = '0;
    logic [4:0]   out_ready = '0;
    logic [4:0]   in_ready;
    logic [4:0]   out_valid;
    logic [127:0] in_state [5];
    logic [127:0] in_key [5];
    logic [127:0] out_state [5];

    for (genvar g = 0; g < 5; g++) begin : g_dut
        inv_sub_round_if ifc ();
        assign ifc.in_valid  = in_valid[g];
        assign ifc.in_state  = in_state[g];
        assign ifc.in_key    = in_key[g];
        assign ifc.out_ready = out_ready[g];
        assign in_ready[g]   = ifc.in_ready;
        assign out_valid[g]  = ifc.out_valid;
        assign out_state[g]  = ifc.out_state;
        inv_sub_round #(.LANES(1 << g)) dut (
            .clk     (clk),
            .reset_n (reset_n),
            .clr     (clr),
            .bus     (ifc)
        );
    end

    int checks = 0;
    int errors = 0;
    logic [7:0] inv_tab [256];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Forward S-box from the multiplicative generator 3, then inverted into a lookup.
    task automatic build_inv();
        logic [7:0] p, q, x;
        logic [7:0] fwd [256];
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            fwd[p] = x ^ 8'h63;
        end while (p != 8'h01);
        fwd[0] = 8'h63;
        for (int i = 0; i < 256; i++) inv_tab[fwd[i]] = 8'(i);
    endtask

    function automatic logic [127:0] ref_round(input logic [127:0] st, input logic [127:0] ky);
        logic [127:0] res;
        int src, dst;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                src = 4 * ((c - r + 4) % 4) + r;
                dst = 4 * c + r;
                res[127 - 8 * dst -: 8] = inv_tab[st[127 - 8 * src -: 8]] ^ ky[127 - 8 * dst -: 8];
            end
        end
        return res;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Called at a negedge with the instance idle; returns at the negedge after the transfer edge.
    task automatic start_block(input int k, input logic [127:0] st, input logic [127:0] ky,
                               input string tag, output int t0);
        chk({tag, "_in_ready"}, 128'(in_ready[k]), 128'(1));
        in_valid[k] = 1'b1;
        in_state[k] = st;
        in_key[k]   = ky;
        @(posedge clk);
        t0 = cyc;
        @(negedge clk);
        in_valid[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, output int n);
        n = 0;
        while (!out_valid[k] && n < 64) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic finish_block(input int k, input string tag);
        out_ready[k] = 1'b1;
        @(negedge clk);
        out_ready[k] = 1'b0;
        chk({tag, "_idle_ready"}, 128'(in_ready[k]), 128'(1));
        chk({tag, "_idle_valid"}, 128'(out_valid[k]), 128'(0));
    endtask

    task automatic do_block(input int k, input logic [127:0] st, input logic [127:0] ky,
                            input logic [127:0] exp, input string tag, output int t0);
        int n;
        start_block(k, st, ky, tag, t0);
        wait_done(k, n);
        chk({tag, "_latency"}, 128'(n), 128'(16 >> k));
        chk({tag, "_data"}, out_state[k], exp);
        finish_block(k, tag);
    endtask

    initial begin
        int t0, prev, n;
        logic [127:0] st, ky, exp;
        logic seen;

        build_inv();
        for (int k = 0; k < 5; k++) begin
            in_state[k] = '0;
            in_key[k]   = '0;
        end

        #2;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("rst_in_ready_%0d", k), 128'(in_ready[k]), 128'(1));
            chk($sformatf("rst_out_valid_%0d", k), 128'(out_valid[k]), 128'(0));
            chk($sformatf("rst_out_state_%0d", k), out_state[k], 128'(0));
        end
        @(negedge clk);
        reset_n = 1'b1;

        // Transfer on the first edge after reset release.
        do_block(0, 128'(0), 128'(0), {4{32'h52525252}}, "kat_zero", t0);

        st = 128'h637c777b_f26b6fc5_3001672b_fed7ab76;
        for (int k = 0; k < 5; k++)
            do_block(k, st, 128'(0), 128'h000d0a07_04010e0b_0805020f_0c090603,
                     $sformatf("kat_order_l%0d", 1 << k), t0);

        do_block(2, {16{8'h63}}, {16{8'hff}}, {16{8'hff}}, "kat_ff_l4", t0);

        // Downstream stall with in_valid toggling outside IDLE.
        st  = rnd128();
        ky  = rnd128();
        exp = ref_round(st, ky);
        start_block(0, st, ky, "stall", t0);
        in_valid[0] = 1'b1;
        in_state[0] = rnd128();
        in_key[0]   = rnd128();
        wait_done(0, n);
        chk("stall_latency", 128'(n), 128'(16));
        for (int i = 0; i < 10; i++) begin
            in_valid[0] = i[0];
            in_state[0] = rnd128();
            in_key[0]   = rnd128();
            @(negedge clk);
            chk($sformatf("stall_data_%0d", i), out_state[0], exp);
            chk($sformatf("stall_in_ready_%0d", i), 128'(in_ready[0]), 128'(0));
            chk($sformatf("stall_out_valid_%0d", i), 128'(out_valid[0]), 128'(1));
        end
        in_valid[0] = 1'b0;
        finish_block(0, "stall");

        // Reset pulse at BUSY cycle 7.
        start_block(0, rnd128(), rnd128(), "rst_abort", t0);
        repeat (6) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rst_abort_in_ready", 128'(in_ready[0]), 128'(1));
        chk("rst_abort_out_valid", 128'(out_valid[0]), 128'(0));
        chk("rst_abort_out_state", out_state[0], 128'(0));
        @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            seen = seen | out_valid[0];
        end
        chk("rst_abort_no_valid", 128'(seen), 128'(0));
        st = rnd128();
        ky = rnd128();
        do_block(0, st, ky, ref_round(st, ky), "rst_abort_next", t0);

        // Synchronous clear at BUSY cycle 7.
        start_block(0, rnd128(), rnd128(), "clr_abort", t0);
        repeat (6) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_abort_in_ready", 128'(in_ready[0]), 128'(1));
        seen = 1'b0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            seen = seen | out_valid[0];
        end
        chk("clr_abort_no_valid", 128'(seen), 128'(0));
        st = rnd128();
        ky = rnd128();
        do_block(0, st, ky, ref_round(st, ky), "clr_abort_next", t0);

        // Clear wins over a pending output handshake in DONE.
        start_block(1, rnd128(), rnd128(), "clr_done", t0);
        wait_done(1, n);
        clr = 1'b1;
        out_ready[1] = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        out_ready[1] = 1'b0;
        chk("clr_done_out_valid", 128'(out_valid[1]), 128'(0));
        chk("clr_done_in_ready", 128'(in_ready[1]), 128'(1));

        for (int k = 0; k < 5; k++) begin
            prev = 0;
            for (int i = 0; i < 100; i++) begin
                st = rnd128();
                ky = rnd128();
                do_block(k, st, ky, ref_round(st, ky), $sformatf("rand_l%0d_%0d", 1 << k, i), t0);
                if (i > 0)
                    chk($sformatf("spacing_l%0d_%0d", 1 << k, i), 128'(t0 - prev), 128'((16 >> k) + 2));
                prev = t0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/inv_sub_round.md
INV_SUB_ROUND -- requirements
Module: inv_sub_round

Interface
REQ-001 The block SHALL have parameter LANES, default 1, giving bytes processed per cycle; legal values 1, 2, 4, 8, 16.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: in_state and in_key are valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: block can accept a new state.
REQ-006 The block SHALL have port in_state, input, 128 bits: AES state; byte i at [127-8i -: 8], column-major, so byte 4c+r is s[r][c].
REQ-007 The block SHALL have port in_key, input, 128 bits: round key, same byte order as in_state.
REQ-008 The block SHALL have port out_valid, output, 1 bit: out_state holds a completed result.
REQ-009 The block SHALL have port out_ready, input, 1 bit: downstream (inverse mixcolumns stage) accepts out_state.
REQ-010 The block SHALL have port out_state, output, 128 bits: AddRoundKey(InvSubBytes(InvShiftRows(in_state)), in_key), in the same byte order.
REQ-011 The block SHALL have port clr, input, 1 bit: synchronous abort.

Function
REQ-012 An input transfer SHALL occur on a rising edge where in_valid=1 and in_ready=1; an output transfer SHALL occur where out_valid=1 and out_ready=1.
REQ-013 The FSM SHALL have exactly three states, IDLE, BUSY and DONE; in_ready=1 only in IDLE and out_valid=1 only in DONE.
REQ-014 In IDLE, an input transfer SHALL capture in_state (with InvShiftRows applied: s'[r][c] = s[r][(c-r) mod 4]) and in_key into internal registers, clear byte index idx to 0, and go to BUSY.
REQ-015 In BUSY, each cycle SHALL replace bytes idx..idx+LANES-1 of the working register with InvSbox(byte) XOR key byte, using LANES combinational inverse S-box lookups per FIPS-197 Figure 14.
REQ-016 After each BUSY cycle, idx SHALL advance by LANES, and the FSM SHALL go to DONE on the cycle that processes byte 15 (idx+LANES = 16); idx SHALL never exceed 15 and SHALL be 4 bits wide.
REQ-017 out_valid SHALL rise exactly 16/LANES cycles after the input-transfer edge; the bytes of out_state at that point SHALL be the final result.
REQ-018 out_state SHALL stay stable while out_valid=1 and out_ready=0, for any stall length.
REQ-019 In DONE, an output transfer SHALL move the FSM to IDLE; in_ready SHALL be 1 on the following cycle, giving back-to-back throughput of one block per 16/LANES+2 cycles.
REQ-020 in_valid asserted outside IDLE SHALL be ignored, and in_state and in_key SHALL NOT be sampled.
REQ-021 clr=1 SHALL force the FSM to IDLE and idx to 0 on the next edge from any state, discarding any partial or pending result; clr SHALL take priority over both handshakes.
REQ-022 out_state SHALL be registered, and only bytes in the current lane window SHALL change in any given cycle.

Reset
REQ-023 While reset_n=0, the block SHALL hold FSM=IDLE, idx=0, in_ready=1, out_valid=0, out_state=0 and internal key=0, independent of clk.
REQ-024 Reset asserted mid-BUSY or in DONE SHALL abandon the operation, and no out_valid pulse SHALL follow deassertion.
REQ-025 The first input transfer SHALL be possible on the first rising edge after reset_n deasserts.

Verification
REQ-026 The bench SHALL check: LANES=1, in_state=0, in_key=0 -> out_valid exactly 16 cycles after transfer, out_state=52525252_52525252_52525252_52525252.
REQ-027 The bench SHALL check: in_state=637c777b_f26b6fc5_3001672b_fed7ab76, in_key=0 -> out_state=000d0a07_04010e0b_0805020f_0c090603, which verifies shift direction and byte order.
REQ-028 The bench SHALL check: in_state all 0x63, in_key all 0xFF, LANES=4 -> out_valid 4 cycles after transfer, out_state all 0xFF.
REQ-029 The bench SHALL check: out_ready held 0 for 10 cycles in DONE -> out_state constant, in_ready=0 throughout, and in_valid pulses ignored.
REQ-030 The bench SHALL check: reset_n pulsed low at BUSY cycle 7, and separately clr=1 at cycle 7 -> IDLE, out_valid never asserts, and a following block completes correctly.
REQ-031 The bench SHALL check: 100 random back-to-back blocks for each LANES value against a software model -> all match, with a spacing of 16/LANES+2 cycles.
